// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and bus constants for the sprite DMA engine / bus arbiter.
package oam_dma_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] DMA_TRIG_ADDR_C = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_C = 16'h2004;
    localparam int unsigned XFER_LEN_C      = 256;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Sprite DMA engine: stalls the CPU, copies one page into the OAM data port,
// then hands the bus back to the CPU.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
#(
    parameter logic [15:0] DMA_TRIG_ADDR = DMA_TRIG_ADDR_C,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_C,
    parameter int unsigned XFER_LEN      = XFER_LEN_C
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    input  logic [7:0]  bus_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic       parity_q, parity_d;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            page_q   <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        parity_d   = ~parity_q;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        bus_addr   = cpu_addr;
        bus_wdata  = cpu_wdata;
        bus_we     = 1'b0;

        case (state_q)
            IDLE: begin
                cpu_rdy    = 1'b1;
                dma_active = 1'b0;
                bus_we     = cpu_we;
                if (cpu_we && (cpu_addr == DMA_TRIG_ADDR)) begin
                    page_d  = cpu_wdata;
                    idx_d   = '0;
                    state_d = HALT;
                end
            end
            // An odd DMA start needs one extra dummy cycle to realign reads.
            HALT:  state_d = parity_q ? ALIGN : READ;
            ALIGN: state_d = READ;
            READ: begin
                bus_addr = {page_q, idx_q};
                state_d  = WRITE;
            end
            WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_we    = 1'b1;
                bus_wdata = bus_rdata;
                idx_d     = idx_q + 8'd1;
                state_d   = (idx_q == LAST_IDX) ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
